// File: rtl/acq_search_ctrl.sv
// acq_search_ctrl
//   Bus-master sequencer for correlator channel 00 performing a frequency-bin
//   acquisition search. For each bin it programs the carrier DDS step, chip DDS
//   and PRN seed, enables the channel, discards SKIP_EPOCHS partial epochs and
//   then captures one full 64-bit correlation. The bin with the largest |corr|
//   is reported.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start, abort       1-cycle control pulses from the host
//   freq_start/step    carrier DDS add value for bin 0 and per-bin increment
//   num_bins           number of bins to search (0 => immediate done)
//   chip_freq          chip DDS frequency word
//   prn_init           PRN seed {hob[3:0], poly[13:0], value[13:0]}
//   corr_seen          CorrelationSeen02 status from the correlator
//   m_addr/m_wdata     correlator bus address / write data (0 when idle)
//   m_write/m_read     one-cycle access strobes; m_rdata is combinational
//   busy, done, err    status: running, end-of-run pulse, sticky timeout
//   best_bin/best_mag  bin index and unsigned magnitude of the largest |corr|

module acq_search_ctrl #(
    parameter logic [31:0] TIMEOUT     = 32'd1000000,
    parameter logic [1:0]  SKIP_EPOCHS = 2'd1,
    parameter int unsigned BIN_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      freq_start,
    input  logic [31:0]      freq_step,
    input  logic [BIN_W-1:0] num_bins,
    input  logic [31:0]      chip_freq,
    input  logic [31:0]      prn_init,
    input  logic             corr_seen,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    output logic             m_write,
    output logic             m_read,
    input  logic [31:0]      m_rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] best_bin,
    output logic [63:0]      best_mag
);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StCfg   = 4'd1;
    localparam logic [3:0] StWait  = 4'd2;
    localparam logic [3:0] StRdLo  = 4'd3;
    localparam logic [3:0] StRdHi  = 4'd4;
    localparam logic [3:0] StRdSt  = 4'd5;
    localparam logic [3:0] StGuard = 4'd6;
    localparam logic [3:0] StNext  = 4'd7;
    localparam logic [3:0] StStop  = 4'd8;

    localparam logic [31:0] AddrCtrl     = 32'hFE00_0100;
    localparam logic [31:0] AddrFreqAdd  = 32'hFE00_0220;
    localparam logic [31:0] AddrFreqPh   = 32'hFE00_0224;
    localparam logic [31:0] AddrFreqLd   = 32'hFE00_022C;
    localparam logic [31:0] AddrChipFreq = 32'hFE00_0420;
    localparam logic [31:0] AddrChipPh   = 32'hFE00_0424;
    localparam logic [31:0] AddrPrn      = 32'hFE00_042C;
    localparam logic [31:0] AddrCorrLo   = 32'hFE00_0624;
    localparam logic [31:0] AddrCorrHi   = 32'hFE00_0628;
    localparam logic [31:0] AddrCorrSt   = 32'hFE00_062C;

    logic [3:0]       state_q, state_d;
    logic [2:0]       cfg_idx_q, cfg_idx_d;
    logic [31:0]      tmo_q, tmo_d;
    logic [1:0]       skip_q, skip_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BIN_W-1:0] nbins_q, nbins_d;
    logic [31:0]      fadd_q, fadd_d;
    logic [31:0]      fstep_q, fstep_d;
    logic [31:0]      chip_q, chip_d;
    logic [31:0]      prn_q, prn_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [63:0]      best_mag_q, best_mag_d;
    logic [BIN_W-1:0] best_bin_q, best_bin_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [63:0] corr_raw;
    logic [63:0] corr_mag;

    // Two's-complement negate; -2^63 stays 2^63 when read as unsigned.
    assign corr_raw = {hi_q, lo_q};
    assign corr_mag = corr_raw[63] ? (~corr_raw + 64'd1) : corr_raw;

    always_comb begin
        state_d    = state_q;
        cfg_idx_d  = cfg_idx_q;
        tmo_d      = tmo_q;
        skip_d     = skip_q;
        bin_d      = bin_q;
        nbins_d    = nbins_q;
        fadd_d     = fadd_q;
        fstep_d    = fstep_q;
        chip_d     = chip_q;
        prn_d      = prn_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        best_mag_d = best_mag_q;
        best_bin_d = best_bin_q;
        err_d      = err_q;
        done_d     = 1'b0;
        m_write    = 1'b0;
        m_read     = 1'b0;
        m_addr     = 32'd0;
        m_wdata    = 32'd0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    nbins_d    = num_bins;
                    fstep_d    = freq_step;
                    chip_d     = chip_freq;
                    prn_d      = prn_init;
                    fadd_d     = freq_start;
                    bin_d      = '0;
                    best_mag_d = 64'd0;
                    best_bin_d = '0;
                    err_d      = 1'b0;
                    skip_d     = SKIP_EPOCHS;
                    cfg_idx_d  = 3'd0;
                    // An empty search still passes through STOP so done pulses.
                    state_d    = (num_bins == '0) ? StStop : StCfg;
                end
            end
            StCfg: begin
                m_write = 1'b1;
                case (cfg_idx_q)
                    3'd0: begin m_addr = AddrCtrl;     m_wdata = 32'd0;  end
                    3'd1: begin m_addr = AddrFreqAdd;  m_wdata = fadd_q; end
                    3'd2: begin m_addr = AddrFreqPh;   m_wdata = 32'd0;  end
                    3'd3: begin m_addr = AddrChipFreq; m_wdata = chip_q; end
                    3'd4: begin m_addr = AddrChipPh;   m_wdata = 32'd0;  end
                    3'd5: begin m_addr = AddrPrn;      m_wdata = prn_q;  end
                    3'd6: begin m_addr = AddrFreqLd;   m_wdata = 32'd1;  end
                    default: begin m_addr = AddrCtrl;  m_wdata = 32'd1;  end
                endcase
                cfg_idx_d = cfg_idx_q + 3'd1;
                if (cfg_idx_q == 3'd7) begin
                    tmo_d   = 32'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (corr_seen) begin
                    state_d = StRdLo;
                end else if (tmo_q == TIMEOUT - 32'd1) begin
                    err_d   = 1'b1;
                    state_d = StStop;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StRdLo: begin
                m_read  = 1'b1;
                m_addr  = AddrCorrLo;
                lo_d    = m_rdata;
                state_d = StRdHi;
            end
            StRdHi: begin
                m_read  = 1'b1;
                m_addr  = AddrCorrHi;
                hi_d    = m_rdata;
                state_d = StRdSt;
            end
            StRdSt: begin
                // Reading the status register clears CorrelationSeen.
                m_read  = 1'b1;
                m_addr  = AddrCorrSt;
                state_d = StGuard;
            end
            StGuard: begin
                // Idle cycle so the seen-clear lands before corr_seen is sampled again.
                if (skip_q != 2'd0) begin
                    skip_d  = skip_q - 2'd1;
                    tmo_d   = 32'd0;
                    state_d = StWait;
                end else begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (corr_mag > best_mag_q) begin
                    best_mag_d = corr_mag;
                    best_bin_d = bin_q;
                end
                if (bin_q == nbins_q - BIN_W'(1)) begin
                    state_d = StStop;
                end else begin
                    bin_d     = bin_q + BIN_W'(1);
                    fadd_d    = fadd_q + fstep_q;
                    skip_d    = SKIP_EPOCHS;
                    cfg_idx_d = 3'd0;
                    state_d   = StCfg;
                end
            end
            StStop: begin
                // The channel was never enabled for an empty search, so skip the disable.
                if (nbins_q != '0) begin
                    m_write = 1'b1;
                    m_addr  = AddrCtrl;
                    m_wdata = 32'd0;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The current cycle's access has already been issued above; only redirect.
        if (abort && state_q != StIdle && state_q != StStop) begin
            state_d = StStop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cfg_idx_q  <= 3'd0;
            tmo_q      <= 32'd0;
            skip_q     <= 2'd0;
            bin_q      <= '0;
            nbins_q    <= '0;
            fadd_q     <= 32'd0;
            fstep_q    <= 32'd0;
            chip_q     <= 32'd0;
            prn_q      <= 32'd0;
            lo_q       <= 32'd0;
            hi_q       <= 32'd0;
            best_mag_q <= 64'd0;
            best_bin_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_idx_q  <= cfg_idx_d;
            tmo_q      <= tmo_d;
            skip_q     <= skip_d;
            bin_q      <= bin_d;
            nbins_q    <= nbins_d;
            fadd_q     <= fadd_d;
            fstep_q    <= fstep_d;
            chip_q     <= chip_d;
            prn_q      <= prn_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            best_mag_q <= best_mag_d;
            best_bin_q <= best_bin_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign err      = err_q;
    assign best_bin = best_bin_q;
    assign best_mag = best_mag_q;

endmodule
